// File: rtl/lpf_power_trigger.sv
// Windowed power detector and trigger for the 8-lane lowpass output.
// Each clock's 8 samples are squared and summed (two pipeline stages), the
// per-beat sums are integrated over a programmable window of valid beats, and
// a trigger FSM fires when a completed window's power exceeds a threshold.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// DISARMED | triggering disabled (arm_i low); windowing still runs
// ARMED    | next window close with power > thresh_i fires trig_o
// HOLDOFF  | counting down hold_cnt; window closes never trigger here
module lpf_power_trigger #(
    parameter  int INBITS   = 13,
    parameter  int WINBITS  = 4,
    parameter  int HOLDBITS = 16,
    localparam int ACCBITS  = 2*INBITS + 3 + WINBITS
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [7:0][INBITS-1:0]        dat_i,
    input  logic                          dat_valid_i,
    input  logic [WINBITS-1:0]            win_len_i,
    input  logic [ACCBITS-1:0]            thresh_i,
    input  logic [HOLDBITS-1:0]           holdoff_i,
    input  logic                          arm_i,
    output logic [ACCBITS-1:0]            power_o,
    output logic                          power_valid_o,
    output logic                          trig_o,
    output logic [1:0]                    state_o
);

    localparam int SQBITS  = 2*INBITS;
    localparam int SUMBITS = 2*INBITS + 3;

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        HOLDOFF  = 2'b10
    } state_t;

    logic [7:0][SQBITS-1:0]  sq_q, sq_d;
    logic                    v1_q, v1_d;
    logic [SUMBITS-1:0]      sum2_q, sum2_d;
    logic                    v2_q, v2_d;
    logic [ACCBITS-1:0]      acc_q, acc_d;
    logic [WINBITS-1:0]      cnt_q, cnt_d;
    logic [WINBITS-1:0]      wlen_q, wlen_d;
    logic                    wlen_ld_q, wlen_ld_d;
    logic [ACCBITS-1:0]      power_q, power_d;
    logic                    pv_q, pv_d;
    logic                    trig_q, trig_d;
    state_t                  state_q, state_d;
    logic [HOLDBITS-1:0]     hold_q, hold_d;

    logic [ACCBITS-1:0]      acc_sum;
    logic                    win_close;
    logic                    hit;

    // Stage 1: square each signed sample; -4096^2 = 2^24 still fits unsigned.
    always_comb begin : square_comb
        logic signed [SQBITS-1:0] sext;
        sext = '0;
        for (int i = 0; i < 8; i++) begin
            sext    = {{INBITS{dat_i[i][INBITS-1]}}, dat_i[i]};
            sq_d[i] = sext * sext;
        end
        v1_d = dat_valid_i;
    end

    // Stage 2: sum the 8 squares; 3 extra bits cover the 8-way growth.
    always_comb begin
        sum2_d = '0;
        for (int i = 0; i < 8; i++) begin
            sum2_d = sum2_d + {3'b000, sq_q[i]};
        end
        v2_d = v1_q;
    end

    // Window integration; wlen reloads at reset release and at each window close.
    always_comb begin
        acc_sum   = acc_q + {{(ACCBITS-SUMBITS){1'b0}}, sum2_q};
        win_close = v2_q && (cnt_q == wlen_q);
        hit       = acc_sum > thresh_i;

        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wlen_d    = wlen_q;
        wlen_ld_d = 1'b1;
        power_d   = power_q;
        pv_d      = 1'b0;

        if (!wlen_ld_q) begin
            wlen_d = win_len_i;
        end

        if (v2_q) begin
            if (win_close) begin
                power_d = acc_sum;
                pv_d    = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                wlen_d  = win_len_i;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + WINBITS'(1);
            end
        end
    end

    // Trigger FSM next state; a low arm_i overrides everything, including a hit.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        trig_d  = 1'b0;

        if (!arm_i) begin
            state_d = DISARMED;
            hold_d  = '0;
        end else begin
            case (state_q)
                DISARMED: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (win_close && hit) begin
                        trig_d  = 1'b1;
                        state_d = HOLDOFF;
                        hold_d  = holdoff_i;
                    end
                end
                HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_d = ARMED;
                    end else begin
                        hold_d = hold_q - HOLDBITS'(1);
                    end
                end
                default: begin
                    state_d = DISARMED;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Pipeline, accumulator and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_q      <= '0;
            v1_q      <= 1'b0;
            sum2_q    <= '0;
            v2_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            wlen_q    <= '0;
            wlen_ld_q <= 1'b0;
            power_q   <= '0;
            pv_q      <= 1'b0;
        end else begin
            sq_q      <= sq_d;
            v1_q      <= v1_d;
            sum2_q    <= sum2_d;
            v2_q      <= v2_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wlen_q    <= wlen_d;
            wlen_ld_q <= wlen_ld_d;
            power_q   <= power_d;
            pv_q      <= pv_d;
        end
    end

    // Trigger FSM state, holdoff counter and trigger pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DISARMED;
            hold_q  <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
        end
    end

    assign power_o       = power_q;
    assign power_valid_o = pv_q;
    assign trig_o        = trig_q;
    assign state_o       = state_q;

endmodule

// File: doc/lpf_power_trigger.md
Name: lpf_power_trigger

Overview:
- Consumes the 8-sample/clock, 13-bit signed output of the Shannon-Whitaker lowpass stage.
- Squares and sums each clock's 8 samples, integrates over a programmable window of clocks, and reports a windowed power value.
- A trigger FSM fires when the windowed power exceeds a threshold, then enforces a holdoff before it re-arms.
- Sits directly downstream of the lowpass filter and feeds the trigger/readout logic.

Parameters:
- INBITS, 13, signed sample width (equals the lowpass OUTBITS).
- WINBITS, 4, window-length control width. Maximum window is 2^WINBITS clocks.
- HOLDBITS, 16, holdoff counter width.
- ACCBITS (localparam), 2*INBITS+3+WINBITS, unsigned power width (33 at defaults).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- dat_i  in  8*INBITS  8 signed samples, packed [7:0][INBITS-1:0]
- dat_valid_i  in  1  dat_i qualifier for this clock
- win_len_i  in  WINBITS  window length in valid beats minus 1
- thresh_i  in  ACCBITS  unsigned trigger threshold
- holdoff_i  in  HOLDBITS  holdoff length in clocks minus 1
- arm_i  in  1  level; 1 enables triggering
- power_o  out  ACCBITS  last completed window power
- power_valid_o  out  1  one-cycle pulse when power_o updates
- trig_o  out  1  one-cycle trigger pulse
- state_o  out  2  FSM state: 00 DISARMED, 01 ARMED, 10 HOLDOFF

Behaviour:
- Reset: asynchronous and active-low. While rst_ni=0, every register clears:
  - power_o=0, power_valid_o=0, trig_o=0, state_o=00.
  - Accumulator, window counter, holdoff counter and pipeline valids all clear.
  - Reset mid-window discards the partial window; no power_valid_o is emitted for it.
- Pipeline:
  - S1: 8 registered squares, each 2*INBITS bits unsigned. The square of -4096 is 2^24, which fits.
  - S2: registered sum of the 8 squares, 2*INBITS+3 bits.
  - dat_valid_i travels alongside the data as v1 and v2.
  - Per-beat sum arrives at the accumulator 2 clocks after input.
  - power_o and power_valid_o register 1 clock later, i.e. 3 clocks after the last beat of the window.
- Window:
  - wlen is latched from win_len_i at reset release and at each window close. A change mid-window takes effect next window.
  - Beats with v2=1 count; beats with v2=0 leave the accumulator and counter unchanged.
  - On a counted beat with count==wlen:
    - power_o <= acc+sum2 and power_valid_o=1 for one clock.
    - acc <= 0 and count <= 0.
  - Otherwise, on a counted beat: acc <= acc+sum2 and count increments.
  - The accumulator cannot overflow by construction: 16 beats × 8 × 2^24 = 2^31 < 2^33.
- Trigger compare:
  - hit = (acc+sum2) > thresh_i, unsigned and strict, evaluated on the window-closing beat.
  - trig_o registers in the same cycle as power_valid_o.
- FSM:
  - DISARMED: when arm_i=1, go to ARMED on the next clock.
  - ARMED: on a window close with hit=1, trig_o=1 and go to HOLDOFF; hold_cnt <= holdoff_i.
  - HOLDOFF: hold_cnt decrements each clock. When hold_cnt==0, go to ARMED. HOLDOFF therefore lasts holdoff_i+1 clocks.
  - Window closes during HOLDOFF or DISARMED still update power_o but never assert trig_o.
  - arm_i=0 in any state: go to DISARMED on the next clock and clear hold_cnt. arm_i has priority over a simultaneous hit, so trig_o is not asserted.
  - Unused encoding 11: recover to DISARMED.
- Windowing runs independently of the FSM state.

Test Plan:
- Constant input, all 8 samples = 100, dat_valid_i=1, win_len_i=3:
  - power_o = 4×8×10000 = 320000.
  - power_valid_o pulses every 4 clocks.
  - First pulse occurs 6 clocks after the first valid input beat.
- Threshold boundary: arm_i=1, same stimulus.
  - thresh_i=319999: trig_o pulses with the first power_valid_o, then state_o=10.
  - thresh_i=320000: trig_o is never asserted.
- Holdoff timing: thresh_i=0, holdoff_i=9.
  - state_o=10 for exactly 10 clocks after trig_o, then 01.
  - A window closing inside holdoff gives power_valid_o=1 and trig_o=0.
- Valid gaps: win_len_i=1, samples = -4096.
  - dat_valid_i alternates 1,0,1,0.
  - power_o = 2×8×2^24 = 268435456; power_valid_o fires once per 4 clocks.
  - Repeat with win_len_i=15: power_o = 2^31, with no overflow.
- Disarm and reset:
  - Drop arm_i on the same cycle as a would-be hit: trig_o=0 and state_o=00.
  - Assert rst_ni=0 mid-window, then release: all outputs are 0, and the next power_o covers only post-reset beats.
